// File: rtl/sad_frame_loader.sv
// Raster-order pixel loader that scatters a 64-column frame across 16 MultiMem banks.
// Optional running pixel checksum is built only when LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps

module sad_frame_loader #(
    parameter int unsigned ROWS = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  PixelIn,
    input  logic        PixelValid,
    output logic        PixelReady,
    output logic [15:0] BankWe,
    output logic [7:0]  MemAddress,
    output logic [7:0]  MemWriteData,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Checksum
);

    localparam logic [5:0] LastRow = 6'(ROWS - 1);
    localparam logic [5:0] LastCol = 6'd63;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic [15:0] we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        xfer;
    logic        last_pix;
    logic        frame_start;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        we_d        = '0;
        addr_d      = addr_q;
        data_d      = data_q;
        xfer        = PixelValid && (state_q == StLoad);
        last_pix    = xfer && (row_q == LastRow) && (col_q == LastCol);
        frame_start = (state_q == StIdle) && Start;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StLoad;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StLoad: begin
                if (last_pix) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Bank is the low column nibble; each bank row holds four 16-pixel column groups.
        if (xfer) begin
            col_d  = col_q + 6'd1;
            if (col_q == LastCol) begin
                row_d = row_q + 6'd1;
            end
            we_d   = 16'h0001 << col_q[3:0];
            addr_d = {row_q, col_q[5:4]};
            data_d = PixelIn;
        end
    end

    assign PixelReady   = (state_q == StLoad);
    assign Busy         = (state_q != StIdle);
    assign Done         = (state_q == StDone);
    assign BankWe       = we_q;
    assign MemAddress   = addr_q;
    assign MemWriteData = data_q;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (frame_start) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + {8'h00, PixelIn};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign Checksum = sum_q;
`else
    assign Checksum = '0;
`endif

endmodule

// File: tb/tb_sad_frame_loader.sv
// Directed self-checking bench for sad_frame_loader: full frames, valid gaps, reset abort,
// Start during load and a single-row instance.
`timescale 1ns/1ps

module tb_sad_frame_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic        valid;
    logic [7:0]  pix;

    logic        ready0, busy0, done0;
    logic [15:0] we0, sum0;
    logic [7:0]  addr0, data0;
    logic        ready1, busy1, done1;
    logic [15:0] we1, sum1;
    logic [7:0]  addr1, data1;

    logic        sel;
    logic        s_ready, s_busy, s_done;
    logic [15:0] s_we, s_sum;
    logic [7:0]  s_addr, s_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sad_frame_loader #(.ROWS(64)) dut0 (
        .Clk(clk), .Reset(reset), .Start(start0), .PixelIn(pix), .PixelValid(valid),
        .PixelReady(ready0), .BankWe(we0), .MemAddress(addr0), .MemWriteData(data0),
        .Busy(busy0), .Done(done0), .Checksum(sum0)
    );

    sad_frame_loader #(.ROWS(1)) dut1 (
        .Clk(clk), .Reset(reset), .Start(start1), .PixelIn(pix), .PixelValid(valid),
        .PixelReady(ready1), .BankWe(we1), .MemAddress(addr1), .MemWriteData(data1),
        .Busy(busy1), .Done(done1), .Checksum(sum1)
    );

    assign s_ready = sel ? ready1 : ready0;
    assign s_busy  = sel ? busy1  : busy0;
    assign s_done  = sel ? done1  : done0;
    assign s_we    = sel ? we1    : we0;
    assign s_sum   = sel ? sum1   : sum0;
    assign s_addr  = sel ? addr1  : addr0;
    assign s_data  = sel ? data1  : data0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one frame with pixel value = index mod 256 and checks every write against
    // the raster mapping. abort_after>0 fires Reset once that many transfers are done.
    task automatic run_frame(input bit one, input int rows, input bit toggle,
                             input int abort_after, input bit start_mid, input string nm);
        int          idx = 0, wr_idx = 0, wr_err = 0, done_cnt = 0, done_cyc = 0;
        int          cyc, bound, ck_err = 0, done_bad = 0, k;
        bit          prev_xfer = 0, v, finished = 0;
        logic [15:0] exp_sum = '0, exp_we, first_we = '0, last_we = '0;
        logic [7:0]  exp_addr, first_addr = 8'hff, last_addr = '0, b5a1 = '0;
        logic [31:0] wr_vec;

        sel   = one;
        bound = rows * 64 * 3 + 50;
        @(negedge clk);
        if (one) start1 = 1'b1;
        else     start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        cyc    = 1;
        while (!finished && cyc < bound) begin
            if (s_we != 16'h0) begin
                wr_vec   = 32'(wr_idx);
                exp_we   = 16'h0001 << wr_vec[3:0];
                exp_addr = {wr_vec[11:6], wr_vec[5:4]};
                if (s_we !== exp_we || s_addr !== exp_addr || s_data !== wr_vec[7:0]) wr_err++;
                if (wr_idx == 0) begin
                    first_we   = s_we;
                    first_addr = s_addr;
                end
                if (s_we[5] && s_addr == 8'h01) b5a1 = s_data;
                last_we   = s_we;
                last_addr = s_addr;
                wr_idx++;
            end
`ifndef LOADER_CHECKSUM_EN
            if (s_sum !== 16'h0) ck_err++;
`endif
            if (s_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (s_ready || s_we == 16'h0) done_bad++;
            end
            if (prev_xfer) begin
                exp_sum = exp_sum + 16'(idx % 256);
                idx++;
            end
            if (abort_after != 0 && idx == abort_after) begin
                reset  = 1'b1;
                start0 = 1'b1;
                valid  = 1'b1;
                @(negedge clk);
                check_eq({nm, "_abort_we"}, s_we, 0);
                check_eq({nm, "_abort_busy"}, s_busy, 0);
                check_eq({nm, "_abort_done"}, s_done, 0);
                check_eq({nm, "_abort_ready"}, s_ready, 0);
                check_eq({nm, "_abort_addr"}, s_addr, 0);
                check_eq({nm, "_abort_sum"}, s_sum, 0);
                check_eq({nm, "_abort_writes"}, wr_idx, abort_after);
                check_eq({nm, "_abort_wrseq"}, wr_err, 0);
                reset  = 1'b0;
                start0 = 1'b0;
                valid  = 1'b0;
                return;
            end
            if (done_cnt != 0 && !s_done) begin
                check_eq({nm, "_idle_after_done"}, s_busy, 0);
                finished = 1;
            end else begin
                k     = cyc - 1;
                v     = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
                valid = v;
                pix   = 8'(idx % 256);
                if (start_mid) start0 = (cyc == 50);
                prev_xfer = v && s_ready;
                cyc++;
                @(negedge clk);
            end
        end
        valid = 1'b0;
        check_eq({nm, "_finished"}, finished, 1);
        check_eq({nm, "_writes"}, wr_idx, rows * 64);
        check_eq({nm, "_wrseq"}, wr_err, 0);
        check_eq({nm, "_done_cnt"}, done_cnt, 1);
        check_eq({nm, "_done_align"}, done_bad, 0);
        if (!toggle) check_eq({nm, "_done_cyc"}, done_cyc, rows * 64 + 1);
        check_eq({nm, "_first_we"}, first_we, 16'h0001);
        check_eq({nm, "_first_addr"}, first_addr, 8'h00);
        check_eq({nm, "_last_we"}, last_we, 16'h8000);
        check_eq({nm, "_last_addr"}, last_addr, ((rows - 1) << 2) | 3);
        if (rows == 64) check_eq({nm, "_b5_a1"}, b5a1, 8'h15);
`ifdef LOADER_CHECKSUM_EN
        check_eq({nm, "_checksum"}, s_sum, exp_sum);
`else
        check_eq({nm, "_checksum_zero"}, ck_err, 0);
        check_eq({nm, "_checksum_end"}, s_sum, 0);
`endif
    endtask

    initial begin
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        valid  = 1'b0;
        pix    = 8'h00;
        sel    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", ready0, 0);
        check_eq("rst_we", we0, 0);
        check_eq("rst_addr", addr0, 0);
        check_eq("rst_data", data0, 0);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_sum", sum0, 0);
        check_eq("rst_busy_r1", busy1, 0);

        run_frame(1'b0, 64, 1'b0, 0, 1'b0, "full");
        run_frame(1'b0, 64, 1'b1, 0, 1'b0, "gaps");
        run_frame(1'b0, 64, 1'b0, 100, 1'b0, "abort");
        run_frame(1'b0, 64, 1'b0, 0, 1'b0, "reload");
        run_frame(1'b0, 64, 1'b0, 0, 1'b1, "startmid");
        run_frame(1'b1, 1, 1'b0, 0, 1'b0, "rows1");

        @(negedge clk);
        check_eq("final_idle_r1", busy1, 0);
        check_eq("final_idle", busy0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_frame_loader.md
SAD_FRAME_LOADER -- requirements
Module: sad_frame_loader

Interface
REQ-001 SHALL have parameter ROWS, default 64, meaning frame height in rows (1..64); frame width is fixed at 64 columns.
REQ-002 SHALL have port Clk, input, 1, single system clock; all logic on rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Start, input, 1, begin loading one frame (sampled only in IDLE).
REQ-005 SHALL have port PixelIn, input, 8, raster-order pixel data (row-major, column 0 first).
REQ-006 SHALL have port PixelValid, input, 1, PixelIn holds a valid pixel.
REQ-007 SHALL have port PixelReady, output, 1, loader accepts a pixel this cycle.
REQ-008 SHALL have port BankWe, output, 16, one-hot write enable to MultiMem banks 0..15.
REQ-009 SHALL have port MemAddress, output, 8, shared bank address.
REQ-010 SHALL have port MemWriteData, output, 8, shared bank write data.
REQ-011 SHALL have port Busy, output, 1, high in LOAD and DONE states.
REQ-012 SHALL have port Done, output, 1, one-cycle pulse at frame completion.
REQ-013 SHALL have port Checksum, output, 16, running pixel sum (see Configuration).

Function
REQ-014 SHALL implement states IDLE, LOAD, DONE; IDLE->LOAD on Start; LOAD->DONE after the final pixel transfer; DONE->IDLE unconditionally next cycle.
REQ-015 SHALL drive PixelReady=1 only in LOAD; a transfer occurs on an edge where PixelValid&PixelReady.
REQ-016 SHALL keep 6-bit row and column counters, cleared on IDLE->LOAD; column increments per transfer, wraps 63->0 and increments row.
REQ-017 SHALL map pixel (r,c) to bank c[3:0] and address {r[5:0],c[5:4]}.
REQ-018 SHALL register write outputs: a transfer at edge k presents BankWe/MemAddress/MemWriteData for exactly the cycle after edge k; BankWe=0 otherwise.
REQ-019 SHALL treat transfer of (ROWS-1,63) as final: the same edge moves state to DONE, so PixelReady is low the following cycle.
REQ-020 SHALL assert Done for exactly the one cycle spent in DONE, coincident with the final write's BankWe.
REQ-021 SHALL ignore Start while in LOAD or DONE; Start held high in IDLE after DONE begins a new frame.
REQ-022 SHALL stall without counter change on cycles with PixelValid=0 in LOAD; gaps of any length are legal.
REQ-023 SHALL hold MemAddress and MemWriteData at last written values when BankWe=0.

Reset
REQ-024 SHALL on Reset: state IDLE, counters 0, PixelReady 0, BankWe 0, MemAddress 0, MemWriteData 0, Busy 0, Done 0, Checksum 0.
REQ-025 SHALL on Reset mid-LOAD abort the frame immediately with no Done pulse and no write in the next cycle; Reset overrides Start and PixelValid.

Configuration
REQ-026 SHALL, with LOADER_CHECKSUM_EN defined, clear Checksum on IDLE->LOAD and add each transferred pixel (zero-extended, modulo 2^16) at its transfer edge, holding the value after DONE until next Start.
REQ-027 SHALL, without LOADER_CHECKSUM_EN, drive Checksum constant 0 and contain no accumulator logic.

Verification
REQ-028 SHALL cover full frame, ROWS=64, PixelValid=1 continuous, pixel = index mod 256 -> 4096 writes, bank 5 address 0x01 holds 0x15, Done pulse 4097 cycles after Start edge, Checksum 0x7F800 mod 2^16 = 0xF800 with macro.
REQ-029 SHALL cover PixelValid toggling 1,0,0,1 -> exactly one write per valid cycle, counters frozen during gaps, final addresses identical to continuous run.
REQ-030 SHALL cover Reset asserted after 100 transfers -> next cycle BankWe=0, Busy=0, no Done; new Start reloads from (0,0) with bank 0 address 0x00.
REQ-031 SHALL cover Start pulsed during LOAD -> no counter clear, frame completes normally with single Done.
REQ-032 SHALL cover ROWS=1 -> 64 writes, last at bank 15 address 0x03, Done next cycle after 64th transfer, then IDLE.
REQ-033 SHALL cover build without LOADER_CHECKSUM_EN -> Checksum=0 throughout the full-frame scenario.
